// File: rtl/sha3_axis_pkg.sv
// Shared definitions for the SHA3 AXI-Stream block packer.
// Contents:
//   state_e       - packer FSM states (IDLE, FILL, EMIT)
//   PAD_FINAL     - byte OR-ed into the last rate byte of a final block
//   SHA3_SUFFIX   - domain-separation pad byte for SHA3-xxx
//   SHAKE_SUFFIX  - domain-separation pad byte for SHAKE
//   RATE_*        - sponge rates in bytes for the SHA3 family
//   keep_count()  - number of contiguous ones in a TKEEP mask from bit 0
package sha3_axis_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    EMIT
  } state_e;

  localparam logic [7:0] PAD_FINAL    = 8'h80;
  localparam logic [7:0] SHA3_SUFFIX  = 8'h06;
  localparam logic [7:0] SHAKE_SUFFIX = 8'h1F;

  localparam int RATE_224 = 144;
  localparam int RATE_256 = 136;
  localparam int RATE_384 = 104;
  localparam int RATE_512 = 72;

  // Widest TKEEP the helper accepts; narrower masks are zero-extended,
  // which stops the run of ones at the real mask width.
  localparam int KEEP_MAX = 64;

  // Bytes above the first cleared TKEEP bit are not counted.
  function automatic int keep_count(input logic [KEEP_MAX-1:0] keep);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < KEEP_MAX; i++) begin
      if (run && keep[i]) begin
        n = n + 1;
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/sha3_pad_inject.sv
// Combinational SHA3 multi-rate pad injector.
// Ports:
//   blk_in   in  8*RATE_BYTES  block before padding
//   pad_pos  in  P_W           byte offset that receives PAD_SUFFIX
//   pad_en   in  1             apply padding (block is the final one)
//   blk_out  out 8*RATE_BYTES  block with padding OR-ed in
// When pad_pos is RATE_BYTES-1 both pad bytes land on the same byte,
// giving PAD_SUFFIX | 0x80.
module sha3_pad_inject
  import sha3_axis_pkg::*;
#(
  parameter int         RATE_BYTES = RATE_256,
  parameter logic [7:0] PAD_SUFFIX = SHA3_SUFFIX,
  parameter int         P_W        = 8
) (
  input  logic [8*RATE_BYTES-1:0] blk_in,
  input  logic [P_W-1:0]          pad_pos,
  input  logic                    pad_en,
  output logic [8*RATE_BYTES-1:0] blk_out
);

  always_comb begin
    blk_out = blk_in;
    if (pad_en) begin
      for (int i = 0; i < RATE_BYTES; i++) begin
        if (pad_pos == P_W'(i)) begin
          blk_out[i*8 +: 8] = blk_out[i*8 +: 8] | PAD_SUFFIX;
        end
      end
      blk_out[(RATE_BYTES-1)*8 +: 8] = blk_out[(RATE_BYTES-1)*8 +: 8] | PAD_FINAL;
    end
  end

endmodule

// File: rtl/axis_sha3_block_packer.sv
// AXI-Stream slave that packs message beats into rate-sized blocks for the
// Keccak absorb stage, applying SHA3 padding on the TLAST beat.
// Ports:
//   ACLK, ARESETn      clock; synchronous active-low reset
//   TDATA/TVALID/TREADY/TLAST/TKEEP  AXI-Stream input (TKEEP used on TLAST only)
//   blk_data           out  one rate block, message byte i at [8i+7:8i]
//   blk_valid/blk_ready  block handshake
//   blk_last           out  block is the final, padded block of the message
module axis_sha3_block_packer
  import sha3_axis_pkg::*;
#(
  parameter int         DATA_WIDTH = 16,
  parameter int         RATE_BYTES = RATE_256,
  parameter logic [7:0] PAD_SUFFIX = SHA3_SUFFIX
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [DATA_WIDTH-1:0]   TDATA,
  input  logic                    TVALID,
  output logic                    TREADY,
  input  logic                    TLAST,
  input  logic [DATA_WIDTH/8-1:0] TKEEP,
  output logic [8*RATE_BYTES-1:0] blk_data,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic                    blk_last
);

  localparam int BPW    = DATA_WIDTH / 8;
  localparam int WORDS  = RATE_BYTES / BPW;
  localparam int WCNT_W = $clog2(WORDS + 1);
  localparam int P_W    = $clog2(RATE_BYTES + 1);
  localparam int BLK_W  = 8 * RATE_BYTES;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                pad_pend_q, pad_pend_d;
  logic [BLK_W-1:0]    blk_data_q, blk_data_d;
  logic                blk_last_q, blk_last_d;
  logic                tready_q, tready_d;
  logic                blk_valid_q, blk_valid_d;

  logic [KEEP_MAX-1:0] keep_ext;
  int                  keep_n;
  int                  p_int;
  logic                beat_fire;
  logic                block_end;
  logic [BLK_W-1:0]    beat_block;
  logic [BLK_W-1:0]    pad_blk_in;
  logic [BLK_W-1:0]    pad_blk_out;
  logic [P_W-1:0]      pad_pos;
  logic                pad_en;

  assign TREADY    = tready_q;
  assign blk_valid = blk_valid_q;
  assign blk_data  = blk_data_q;
  assign blk_last  = blk_last_q;

  // tready_q is only ever high in FILL, so it doubles as the state qualifier.
  assign beat_fire = TVALID && tready_q;
  assign block_end = beat_fire && (TLAST || (wcnt_q == LAST_WORD));

  always_comb begin
    keep_ext             = '0;
    keep_ext[BPW-1:0]    = TKEEP;
    keep_n               = keep_count(keep_ext);
    p_int                = int'(wcnt_q) * BPW + keep_n;
  end

  // Current block with the incoming beat merged in; on TLAST only the
  // first keep_n bytes are written so dropped bytes stay zero.
  always_comb begin
    beat_block = blk_data_q;
    if (state_q == FILL) begin
      for (int b = 0; b < BPW; b++) begin
        if (!TLAST || (b < keep_n)) begin
          beat_block[(int'(wcnt_q) * BPW + b) * 8 +: 8] = TDATA[b*8 +: 8];
        end
      end
    end
  end

  // The single pad injector serves both the last-beat capture and the
  // pad-only block that follows an exactly-full final block.
  always_comb begin
    pad_blk_in = beat_block;
    pad_pos    = P_W'(p_int);
    pad_en     = 1'b0;
    if (beat_fire && TLAST && (p_int < RATE_BYTES)) begin
      pad_en = 1'b1;
    end else if ((state_q == EMIT) && pad_pend_q) begin
      pad_blk_in = '0;
      pad_pos    = '0;
      pad_en     = 1'b1;
    end
  end

  sha3_pad_inject #(
    .RATE_BYTES (RATE_BYTES),
    .PAD_SUFFIX (PAD_SUFFIX),
    .P_W        (P_W)
  ) u_pad (
    .blk_in  (pad_blk_in),
    .pad_pos (pad_pos),
    .pad_en  (pad_en),
    .blk_out (pad_blk_out)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      pad_pend_q  <= 1'b0;
      blk_data_q  <= '0;
      blk_last_q  <= 1'b0;
      tready_q    <= 1'b0;
      blk_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      pad_pend_q  <= pad_pend_d;
      blk_data_q  <= blk_data_d;
      blk_last_q  <= blk_last_d;
      tready_q    <= tready_d;
      blk_valid_q <= blk_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FILL;
      FILL:    if (block_end) state_d = EMIT;
      EMIT:    if (blk_ready && !pad_pend_q) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wcnt_d      = wcnt_q;
    pad_pend_d  = pad_pend_q;
    blk_data_d  = blk_data_q;
    blk_last_d  = blk_last_q;
    case (state_q)
      FILL: begin
        if (beat_fire) begin
          wcnt_d     = wcnt_q + WCNT_W'(1);
          blk_data_d = pad_blk_out;
          if (TLAST && (p_int < RATE_BYTES)) begin
            blk_last_d = 1'b1;
          end else if (TLAST) begin
            // Message ended exactly on the block boundary: the padding
            // needs a block of its own after this one is taken.
            blk_last_d = 1'b0;
            pad_pend_d = 1'b1;
          end else begin
            blk_last_d = 1'b0;
          end
        end
      end
      EMIT: begin
        if (blk_ready) begin
          if (pad_pend_q) begin
            blk_data_d = pad_blk_out;
            blk_last_d = 1'b1;
            pad_pend_d = 1'b0;
          end else begin
            blk_data_d = '0;
            blk_last_d = 1'b0;
            wcnt_d     = '0;
          end
        end
      end
      default: ;
    endcase
    tready_d    = (state_d == FILL);
    blk_valid_d = (state_d == EMIT);
  end

endmodule

// File: tb/tb_axis_sha3_block_packer.sv
module tb_axis_sha3_block_packer;
  import sha3_axis_pkg::*;

  localparam int DATA_WIDTH = 16;
  localparam int BPW        = DATA_WIDTH / 8;
  localparam int RATE       = RATE_256;
  localparam int WORDS      = RATE / BPW;
  localparam int BLK_W      = 8 * RATE;

  typedef byte unsigned bq_t[$];
  typedef struct {
    logic [BLK_W-1:0] data;
    logic             last;
  } exp_t;

  logic                  ACLK = 1'b0;
  logic                  ARESETn;
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TVALID;
  logic                  TREADY;
  logic                  TLAST;
  logic [BPW-1:0]        TKEEP;
  logic [BLK_W-1:0]      blk_data;
  logic                  blk_valid;
  logic                  blk_ready;
  logic                  blk_last;

  exp_t   expQ[$];
  int     checks = 0;
  int     errors = 0;
  int     blocksSeen = 0;
  bit     forceReady = 1'b1;
  bit     forcedVal = 1'b1;
  longint completeTime = -1000;

  axis_sha3_block_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .RATE_BYTES (RATE),
    .PAD_SUFFIX (SHA3_SUFFIX)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .TDATA     (TDATA),
    .TVALID    (TVALID),
    .TREADY    (TREADY),
    .TLAST     (TLAST),
    .TKEEP     (TKEEP),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_last  (blk_last)
  );

  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: SHA3 pad10*1 on the byte string, then cut into rate blocks.
  function automatic void modelPush(input bq_t msg);
    bq_t  q;
    exp_t e;
    int   nBlk;
    q = msg;
    q.push_back(SHA3_SUFFIX);
    while (q.size() % RATE != 0) q.push_back(8'h00);
    q[q.size()-1] = q[q.size()-1] | 8'h80;
    nBlk = q.size() / RATE;
    for (int blk = 0; blk < nBlk; blk++) begin
      e.data = '0;
      for (int i = 0; i < RATE; i++) e.data[i*8 +: 8] = q[blk*RATE + i];
      e.last = (blk == nBlk - 1);
      expQ.push_back(e);
    end
  endfunction

  function automatic bq_t randMsg(input int len);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic sendBeat(input logic [DATA_WIDTH-1:0] d, input logic [BPW-1:0] k,
                          input logic l, input bit completes);
    int waited;
    waited = 0;
    TDATA  = d;
    TKEEP  = k;
    TLAST  = l;
    TVALID = 1'b1;
    forever begin
      @(negedge ACLK);
      if (TREADY === 1'b1) begin
        if (completes) completeTime = longint'($time);
        @(posedge ACLK);
        #1;
        break;
      end
      waited++;
      if (waited > 2000) begin
        checks++;
        errors++;
        $display("[TB] FAIL beat_timeout: got no TREADY, expected handshake within 2000 cycles");
        @(posedge ACLK);
        #1;
        break;
      end
    end
    TVALID = 1'b0;
    TLAST  = 1'b0;
  endtask

  // Sends msg as beats; maxBeats truncates the message (used for the reset case).
  task automatic applyStimulus(input bq_t msg, input bit emptyTail, input bit push, input int maxBeats);
    int L, nFull, rem, j, n;
    bit lastFull, isLast;
    logic [DATA_WIDTH-1:0] d;
    logic [BPW-1:0] k;
    L = msg.size();
    nFull = L / BPW;
    rem = L % BPW;
    j = 0;
    lastFull = (rem == 0) && (L > 0) && !emptyTail;
    if (push) modelPush(msg);
    for (int b = 0; b < nFull; b++) begin
      j++;
      if (j > maxBeats) return;
      isLast = lastFull && (b == nFull - 1);
      for (int i = 0; i < BPW; i++) d[i*8 +: 8] = msg[b*BPW + i];
      k = isLast ? '1 : BPW'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge ACLK);
        #1;
      end
      sendBeat(d, k, isLast, isLast || (j % WORDS == 0));
    end
    if (!lastFull) begin
      j++;
      if (j > maxBeats) return;
      n = rem;
      d = DATA_WIDTH'($urandom);
      for (int i = 0; i < n; i++) d[i*8 +: 8] = msg[nFull*BPW + i];
      k = BPW'((1 << n) - 1);
      if (n < BPW) k = k | (BPW'($urandom) & ~BPW'((1 << (n + 1)) - 1));
      sendBeat(d, k, 1'b1, 1'b1);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (((expQ.size() != 0) || (blk_valid !== 1'b0)) && (w < 5000)) begin
      @(negedge ACLK);
      w++;
    end
    checkOutput("drain_queue_empty", 64'(expQ.size()), 0);
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    blk_ready = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      blk_ready = forceReady ? forcedVal : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each block handshake and checks
  // the handshake invariants every cycle.
  initial begin
    logic             prevValid, prevReady, prevLast;
    logic [BLK_W-1:0] prevData;
    exp_t             e;
    int               badByte;
    prevValid = 1'b0;
    prevReady = 1'b0;
    prevLast  = 1'b0;
    prevData  = '0;
    forever begin
      @(negedge ACLK);
      if (ARESETn !== 1'b1) begin
        prevValid = 1'b0;
        continue;
      end
      if (blk_valid === 1'b1) begin
        checkOutput("tready_low_in_emit", TREADY, 0);
        if (!prevValid)
          checkOutput("valid_latency", 64'(longint'($time) - completeTime), 10);
        if (prevValid && !prevReady) begin
          checkOutput("hold_data", blk_data === prevData, 1);
          checkOutput("hold_last", blk_last, prevLast);
        end
        if (blk_ready === 1'b1) begin
          checks++;
          if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_block%0d: got a block, expected none", blocksSeen);
          end else begin
            e = expQ.pop_front();
            badByte = -1;
            for (int i = RATE - 1; i >= 0; i--)
              if (blk_data[i*8 +: 8] !== e.data[i*8 +: 8]) badByte = i;
            if ((badByte >= 0) || (blk_last !== e.last)) begin
              errors++;
              if (badByte < 0) badByte = 0;
              $display("[TB] FAIL block%0d byte%0d: got %02h expected %02h, last got %0d expected %0d",
                       blocksSeen, badByte, blk_data[badByte*8 +: 8], e.data[badByte*8 +: 8],
                       blk_last, e.last);
            end
          end
          blocksSeen++;
        end
      end
      prevValid = blk_valid;
      prevReady = blk_ready;
      prevLast  = blk_last;
      prevData  = blk_data;
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 60000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bq_t abc;
    abc = '{8'h61, 8'h62, 8'h63};
    ARESETn = 1'b0;
    TVALID  = 1'b0;
    TDATA   = '0;
    TKEEP   = '0;
    TLAST   = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("reset_tready", TREADY, 0);
    checkOutput("reset_blk_valid", blk_valid, 0);
    checkOutput("reset_blk_last", blk_last, 0);
    checkOutput("reset_blk_data_zero", blk_data === '0, 1);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    checkOutput("idle_tready", TREADY, 0);
    @(negedge ACLK);
    checkOutput("fill_tready", TREADY, 1);
    @(posedge ACLK);
    #1;

    // Directed messages with the consumer always ready.
    forceReady = 1'b1;
    forcedVal  = 1'b1;
    applyStimulus(randMsg(0), 1'b0, 1'b1, 1000);
    @(negedge ACLK);
    checkOutput("empty_valid", blk_valid, 1);
    checkOutput("empty_last", blk_last, 1);
    drain();

    applyStimulus(abc, 1'b0, 1'b1, 1000);
    @(negedge ACLK);
    checkOutput("abc_valid", blk_valid, 1);
    checkOutput("abc_byte3", blk_data[31:24], 8'h06);
    drain();

    applyStimulus(randMsg(135), 1'b0, 1'b1, 1000);
    @(negedge ACLK);
    checkOutput("m135_byte135", blk_data[135*8 +: 8], 8'h86);
    checkOutput("m135_last", blk_last, 1);
    drain();

    applyStimulus(randMsg(136), 1'b0, 1'b1, 1000);
    @(negedge ACLK);
    checkOutput("m136_blk1_valid", blk_valid, 1);
    checkOutput("m136_blk1_last", blk_last, 0);
    checkOutput("m136_blk1_tready", TREADY, 0);
    @(negedge ACLK);
    checkOutput("m136_pad_valid", blk_valid, 1);
    checkOutput("m136_pad_last", blk_last, 1);
    checkOutput("m136_pad_tready", TREADY, 0);
    @(negedge ACLK);
    checkOutput("m136_after_valid", blk_valid, 0);
    checkOutput("m136_after_tready", TREADY, 1);
    drain();

    // Backpressure on a full block inside a two-block message.
    forcedVal = 1'b0;
    fork
      applyStimulus(randMsg(200), 1'b0, 1'b1, 1000);
      begin : stall
        logic [BLK_W-1:0] snap;
        int w;
        w = 0;
        while ((blk_valid !== 1'b1) && (w < 2000)) begin
          @(negedge ACLK);
          w++;
        end
        checkOutput("stall_valid_seen", blk_valid, 1);
        snap = blk_data;
        repeat (10) begin
          @(negedge ACLK);
          checkOutput("stall_tready", TREADY, 0);
          checkOutput("stall_data_hold", blk_data === snap, 1);
        end
        forcedVal = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        checkOutput("stall_release_tready", TREADY, 1);
      end
    join
    drain();

    // Reset after 5 beats of a message, then a clean "abc".
    applyStimulus(randMsg(40), 1'b0, 1'b0, 5);
    ARESETn = 1'b0;
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    checkOutput("midreset_tready", TREADY, 0);
    checkOutput("midreset_blk_valid", blk_valid, 0);
    @(posedge ACLK);
    #1;
    applyStimulus(abc, 1'b0, 1'b1, 1000);
    drain();

    // Randomised messages with random consumer stalls.
    forceReady = 1'b0;
    for (int m = 0; m < 40; m++) begin
      int len;
      case ($urandom_range(0, 5))
        0:       len = 135 + int'($urandom_range(0, 1));
        1:       len = 271 + int'($urandom_range(0, 1));
        default: len = int'($urandom_range(0, 300));
      endcase
      applyStimulus(randMsg(len), bit'($urandom_range(0, 1)), 1'b1, 1000);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge ACLK);
        #1;
      end
    end
    drain();
    checkOutput("blocks_seen_nonzero", blocksSeen > 10, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_sha3_block_packer.md
Name: axis_sha3_block_packer

Overview:
- Downstream neighbour of the AXI-Stream receive stage: an AXI-Stream slave that collects message beats into one rate-sized block for the Keccak-f[1600] absorb stage.
- Applies SHA3 multi-rate padding (suffix 0x06 ... final 0x80) on the TLAST beat.
- Emits full blocks on a valid/ready block interface and flags the final block of each message.

Parameters:
- DATA_WIDTH, 16, stream data width in bits; multiple of 8.
- RATE_BYTES, 136, sponge rate in bytes (SHA3-256); must be a multiple of DATA_WIDTH/8.
- PAD_SUFFIX, 8'h06, domain-separation pad byte (8'h1F for SHAKE).

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset; synchronous, active-low; clock ACLK.
- TDATA  in  DATA_WIDTH  message bytes; byte k of the beat is TDATA[8k+7:8k].
- TVALID  in  1  beat valid.
- TREADY  out  1  beat accepted when TVALID && TREADY.
- TLAST  in  1  last beat of the message.
- TKEEP  in  DATA_WIDTH/8  byte-valid mask; used on the TLAST beat only.
- blk_data  out  8*RATE_BYTES  block; message byte i is at [8i+7:8i].
- blk_valid  out  1  block valid.
- blk_ready  in  1  consumer accepts the block.
- blk_last  out  1  block is the final, padded block of the message.

Behaviour:
- Definitions: BPW = DATA_WIDTH/8; WORDS = RATE_BYTES/BPW.
- Reset values: TREADY=0, blk_valid=0, blk_last=0, blk_data=0. Internal: wcnt=0, pad_pend=0, state=IDLE.
- A synchronous reset mid-operation discards any partial block and any pending pad block.
- IDLE (1 cycle after reset release): go to FILL. TREADY, blk_valid and blk_data are registered.
- FILL: TREADY=1, blk_valid=0. Each accepted beat writes BPW bytes at byte offset wcnt*BPW, then wcnt++.
  - Non-last beat with wcnt==WORDS-1: block full. Go to EMIT with blk_last=0. TKEEP is ignored on non-last beats.
  - TLAST beat: n = count of contiguous ones in TKEEP from bit 0. Bytes above the first zero are dropped. p = wcnt*BPW + n.
  - TLAST with p < RATE_BYTES: write only the n bytes. Byte p |= PAD_SUFFIX; byte RATE_BYTES-1 |= 0x80 (0x86 when p==RATE_BYTES-1). Go to EMIT with blk_last=1.
  - TLAST with p == RATE_BYTES (block exactly full): go to EMIT with blk_last=0 and set pad_pend=1.
  - TKEEP==0 on TLAST is legal and means zero bytes; this covers the empty message.
- Padding is applied in the same cycle as the last-beat capture. blk_valid rises the cycle after the completing beat handshake, so fill-to-valid latency is 1 cycle.
- EMIT: TREADY=0; blk_valid=1. blk_data and blk_last are held stable until blk_ready.
  - On handshake with pad_pend=1: load the pad-only block (byte0=PAD_SUFFIX, byte RATE_BYTES-1=0x80, rest 0), set blk_last=1, clear pad_pend, stay in EMIT. blk_valid stays high with no bubble.
  - On handshake with pad_pend=0: clear blk_data to 0, set wcnt=0, go to FILL. TREADY=1 on the next cycle.
- Throughput: WORDS+1 cycles per block when blk_ready is held high.
- The state machine encodes three states: IDLE, FILL, EMIT.

Decomposition:
- Package sha3_axis_pkg:
  - state enum: IDLE, FILL, EMIT.
  - PAD_FINAL = 8'h80.
  - SHA3_SUFFIX = 8'h06; SHAKE_SUFFIX = 8'h1F.
  - Rate constants RATE_224=144, RATE_256=136, RATE_384=104, RATE_512=72.
  - Function keep_count(TKEEP): number of contiguous ones from bit 0.
- One combinational sub-module, sha3_pad_inject: inputs block, p, last flag; output padded block.

Test Plan:
- Empty message: one beat, TLAST=1, TKEEP=2'b00 → one block; byte0=0x06, byte135=0x80, all other bytes 0; blk_last=1.
- "abc":
  - Stimulus: beat 16'h6261 with TKEEP=2'b11, then beat 16'h0063 with TKEEP=2'b01 and TLAST=1.
  - Response: bytes0..3 = 61 62 63 06; byte135=0x80; blk_last=1; blk_valid rises 1 cycle after the second handshake.
- 135-byte message: 67 full beats, then TLAST beat with TKEEP=2'b01 → byte134 = message byte; byte135 = 0x86; exactly one block.
- 136-byte message:
  - Stimulus: 68 full beats, last one TLAST with TKEEP=2'b11.
  - Response: block 1 carries the message with blk_last=0; then a pad-only block (byte0=0x06, byte135=0x80, blk_last=1) follows with no blk_valid gap. TREADY stays 0 until the second handshake.
- Backpressure: hold blk_ready=0 for 10 cycles on a full block → blk_data stable, TREADY=0, no beat accepted or lost; released one cycle later.
- Reset mid-message: pulse ARESETn low after 5 beats → next cycle TREADY=0, blk_valid=0. A following "abc" message yields exactly the block from the "abc" case, with no stale bytes.
